// File: rtl/mem_bank_pkg.sv
// Shared widths, FSM state type and bank decode for the memory-bank master.
// Optional statistics build: MEM_BANK_MASTER_STATS_EN.
package mem_bank_pkg;

   localparam int ADDR_W    = 12;
   localparam int DATA_W    = 8;
   localparam int BANK_W    = 2;
   localparam int NUM_BANKS = 1 << BANK_W;
   localparam int STAT_W    = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      TURN   = 2'd3
   } state_e;

   // The bank is selected by the top address bits.
   function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: BANK_W];
   endfunction

endpackage

// File: rtl/mem_bank_stats.sv
// Per-bank saturating counters of completed accesses.
// Only instantiated when MEM_BANK_MASTER_STATS_EN is defined.
module mem_bank_stats
   import mem_bank_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_i,
   input  logic [BANK_W-1:0] bank_i,
   input  logic [BANK_W-1:0] sel_i,
   output logic [STAT_W-1:0] count_o
);

   logic [NUM_BANKS-1:0][STAT_W-1:0] cnt_q;
   logic [NUM_BANKS-1:0][STAT_W-1:0] cnt_d;

   // Counters stick at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q[bank_i] != '1)) begin
         cnt_d[bank_i] = cnt_q[bank_i] + STAT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q[sel_i];

endmodule

// File: rtl/mem_bank_master.sv
// Single-request master driving a synchronous SRAM-style bank (SETUP/ACCESS/TURN).
// Defining MEM_BANK_MASTER_STATS_EN adds stat_sel/stat_count per-bank access counters.
module mem_bank_master
   import mem_bank_pkg::*;
#(
   parameter int ACCESS_CYCLES     = 2,
   parameter int TURNAROUND_CYCLES = 1
) (
   input  logic              clk,
   input  logic              RESET_N,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_wr,
   output logic [DATA_W-1:0] rsp_data,
   output logic [BANK_W-1:0] rsp_bank,
   output logic              mem_ceb,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
`ifdef MEM_BANK_MASTER_STATS_EN
   ,
   input  logic [BANK_W-1:0] stat_sel,
   output logic [STAT_W-1:0] stat_count
`endif
);

   // Down-counters reload with N-1 so that zero marks the final cycle.
   localparam logic [3:0] ACC_LOAD  = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0] TURN_LOAD = 4'((TURNAROUND_CYCLES > 0) ? (TURNAROUND_CYCLES - 1) : 0);

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              wr_q;
   logic              req_ready_q;
   logic              busy_q;
   logic              rsp_valid_q;
   logic              rsp_wr_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [BANK_W-1:0] rsp_bank_q;
   logic              mem_ceb_q;
   logic              mem_we_q;
   logic              mem_re_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_din_q;

   // mem_addr_q/mem_din_q double as the latched request; they only load in IDLE.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_bank_q  <= '0;
         mem_ceb_q   <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  state_q     <= SETUP;
                  wr_q        <= req_wr;
                  mem_addr_q  <= req_addr;
                  mem_din_q   <= req_wdata;
                  mem_ceb_q   <= 1'b0;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            SETUP: begin
               state_q  <= ACCESS;
               cnt_q    <= ACC_LOAD;
               mem_we_q <= wr_q;
               mem_re_q <= ~wr_q;
            end
            ACCESS: begin
               if (cnt_q == 4'd0) begin
                  mem_we_q    <= 1'b0;
                  mem_re_q    <= 1'b0;
                  mem_ceb_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_wr_q    <= wr_q;
                  rsp_bank_q  <= bank_of(mem_addr_q);
                  rsp_data_q  <= wr_q ? '0 : mem_dout;
                  if (TURNAROUND_CYCLES == 0) begin
                     state_q     <= IDLE;
                     req_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     state_q <= TURN;
                     cnt_q   <= TURN_LOAD;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            TURN: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= IDLE;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_wr    = rsp_wr_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_bank  = rsp_bank_q;
   assign mem_ceb   = mem_ceb_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;

`ifdef MEM_BANK_MASTER_STATS_EN
   mem_bank_stats u_stats (
      .clk     (clk),
      .rst_n   (RESET_N),
      .inc_i   (rsp_valid_q),
      .bank_i  (rsp_bank_q),
      .sel_i   (stat_sel),
      .count_o (stat_count)
   );
`endif

endmodule

// File: tb/tb_mem_bank_master.sv
// Scoreboard bench for mem_bank_master with a behavioural memory bank as the slave.
module tb_mem_bank_master;
   import mem_bank_pkg::*;

   localparam int AC     = 2;
   localparam int TC     = 1;
   localparam int LAT    = AC + 1;
   localparam int PERIOD = 2 + AC + TC;

   logic              clk = 1'b0;
   logic              RESET_N;
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_wr;
   logic [DATA_W-1:0] rsp_data;
   logic [BANK_W-1:0] rsp_bank;
   logic              mem_ceb;
   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic              busy;
`ifdef MEM_BANK_MASTER_STATS_EN
   logic [BANK_W-1:0] stat_sel;
   logic [STAT_W-1:0] stat_count;
`endif

   mem_bank_master #(.ACCESS_CYCLES(AC), .TURNAROUND_CYCLES(TC)) dut (
      .clk       (clk),
      .RESET_N   (RESET_N),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_wr    (rsp_wr),
      .rsp_data  (rsp_data),
      .rsp_bank  (rsp_bank),
      .mem_ceb   (mem_ceb),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .busy      (busy)
`ifdef MEM_BANK_MASTER_STATS_EN
      ,
      .stat_sel  (stat_sel),
      .stat_count(stat_count)
`endif
   );

   always #5 clk = ~clk;

   // Slave memory bank: writes on a clock edge, read data visible while strobed.
   logic [DATA_W-1:0] mem [4096];
   always @(posedge clk) if (!mem_ceb && mem_we) mem[mem_addr] <= mem_din;
   assign mem_dout = (!mem_ceb && mem_re) ? mem[mem_addr] : 8'h00;

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] data;
      logic [BANK_W-1:0] bank;
      int                due;
   } exp_t;

   exp_t              sbq[$];
   logic [DATA_W-1:0] ref_mem [4096];
   int                errors   = 0;
   int                checks   = 0;
   int                cyc      = 0;
   int                strobes  = 0;
   int                last_acc = -1;
   bit                stream_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: each accepted request yields one response, LAT edges later.
   always @(negedge clk) begin : accept_mon
      exp_t e;
      if (RESET_N && req_valid && req_ready) begin
         e.wr    = req_wr;
         e.addr  = req_addr;
         e.wdata = req_wdata;
         e.bank  = 2'(req_addr / 1024);
         e.due   = cyc + 1 + LAT;
         if (req_wr) begin
            ref_mem[req_addr] = req_wdata;
            e.data = 8'h00;
         end else begin
            e.data = ref_mem[req_addr];
         end
         sbq.push_back(e);
         if (stream_on && last_acc >= 0) chk("accept_period", cyc + 1 - last_acc, PERIOD);
         last_acc = cyc + 1;
      end
   end

   always @(negedge clk) begin : rsp_mon
      exp_t e;
      if (RESET_N) begin
         checks++;
         strobe_excl: assert (!(mem_we && mem_re)) else begin
            errors++;
            $display("FAIL strobe_excl: we=%0b re=%0b both high", mem_we, mem_re);
         end
         if (!mem_ceb) begin
            if (sbq.size() == 0) begin
               chk("ce_without_request", 1, 0);
            end else begin
               chk("mem_addr_hold", mem_addr, sbq[0].addr);
               chk("mem_din_hold", mem_din, sbq[0].wdata);
               if (mem_we || mem_re) begin
                  chk("strobe_dir", mem_we, sbq[0].wr);
                  strobes++;
               end
            end
         end else begin
            chk("strobe_while_deselected", {mem_we, mem_re}, 0);
         end
         if (rsp_valid) begin
            if (sbq.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("rsp_wr", rsp_wr, e.wr);
               chk("rsp_data", rsp_data, e.data);
               chk("rsp_bank", rsp_bank, e.bank);
               chk("rsp_latency", cyc, e.due);
               chk("strobe_cycles", strobes, AC);
            end
            strobes = 0;
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!req_ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0 || busy) chk("drain_timeout", 0, 1);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [ADDR_W-1:0] pool [8];
   logic [ADDR_W-1:0] wa [4];
   logic [DATA_W-1:0] wd [4];

   initial begin
      pool[0] = 12'h000; pool[1] = 12'h3FF; pool[2] = 12'h400; pool[3] = 12'h7FE;
      pool[4] = 12'h801; pool[5] = 12'hBFF; pool[6] = 12'hC01; pool[7] = 12'hFFF;
      wa[0] = 12'h1F4; wa[1] = 12'h4B0; wa[2] = 12'hA8C; wa[3] = 12'hDAC;
      wd[0] = 8'h0A;   wd[1] = 8'h0B;   wd[2] = 8'h0C;   wd[3] = 8'h0D;
      RESET_N   = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
`ifdef MEM_BANK_MASTER_STATS_EN
      stat_sel  = '0;
`endif
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_fields", {rsp_wr, rsp_data, rsp_bank}, 0);
      chk("rst_mem_ceb", mem_ceb, 1);
      chk("rst_strobes", {mem_we, mem_re}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      @(negedge clk);
      RESET_N = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_busy", busy, 0);

      // Single write then read-back of the same location.
      issue(1'b1, 12'h1F4, 8'h0A);
      issue(1'b0, 12'h1F4, 8'h00);
      drain();

      // One write per bank, read back in reverse order.
      for (int i = 0; i < 4; i++) issue(1'b1, wa[i], wd[i]);
      for (int i = 3; i >= 0; i--) issue(1'b0, wa[i], 8'h00);
      drain();

      // Request inputs change while the access is in flight.
      issue(1'b1, 12'h2A5, 8'h3C);
      req_addr  = 12'h555;
      req_wdata = 8'hC3;
      repeat (4) @(negedge clk);
      drain();
      issue(1'b0, 12'h2A5, 8'h00);
      drain();

      // req_valid held high across 20 alternating write/read requests.
      stream_on = 1'b1;
      last_acc  = -1;
      req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         req_wr    = (i % 2 == 0);
         req_addr  = pool[(i / 2) % 8];
         req_wdata = 8'($urandom);
         wait_ready();
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      stream_on = 1'b0;
      drain();

      // Randomised traffic over a small address pool, all locations written first.
      for (int i = 0; i < 8; i++) issue(1'b1, pool[i], 8'($urandom));
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom));
      end
      drain();

      // Reset asserted during the ACCESS phase of a write.
      issue(1'b1, 12'hC80, 8'h77);
      @(posedge clk);
      #1;
      chk("pre_rst_we", mem_we, 1);
      RESET_N = 1'b0;
      #1;
      chk("midrst_ceb", mem_ceb, 1);
      chk("midrst_we", mem_we, 0);
      chk("midrst_busy", busy, 0);
      sbq.delete();
      strobes = 0;
      @(negedge clk);
      chk("midrst_rsp_valid", rsp_valid, 0);
      RESET_N = 1'b1;
      @(negedge clk);
      chk("rel_ready", req_ready, 1);
      repeat (3) @(negedge clk);
      chk("rel_no_rsp", rsp_valid, 0);
      issue(1'b1, 12'h123, 8'h45);
      issue(1'b0, 12'h123, 8'h00);
      drain();

`ifdef MEM_BANK_MASTER_STATS_EN
      @(negedge clk);
      RESET_N = 1'b0;
      @(negedge clk);
      RESET_N = 1'b1;
      @(negedge clk);
      issue(1'b1, 12'hC01, 8'h11);
      issue(1'b0, 12'hC01, 8'h00);
      issue(1'b1, 12'hFFF, 8'h22);
      drain();
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         stat_sel = 2'(s);
         #1;
         chk("stat_count", stat_count, (s == 3) ? 3 : 0);
      end
      @(negedge clk);
      dut.u_stats.cnt_q[3] = 16'hFFFF;
      issue(1'b1, 12'hE00, 8'h33);
      drain();
      @(negedge clk);
      stat_sel = 2'd3;
      #1;
      chk("stat_saturate", stat_count, 16'hFFFF);
`endif

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
